// File: rtl/vram_inj_pkg.sv
// Shared types and Game Boy tile-data constants for the VRAM tile injector.
package vram_inj_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    WRITE,
    DONE
  } vram_inj_state_t;

  localparam int          GB_TILE_BYTES     = 16;
  localparam int          GB_TILE_COUNT     = 384;
  localparam logic [12:0] GB_TILE_DATA_END  = 13'h17FF;

endpackage

// File: rtl/tile_byte_buffer.sv
// 16x8 tile staging buffer with a fill counter and an indexed read mux.
module tile_byte_buffer
  import vram_inj_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_idx,
  output logic [3:0] byte_cnt,
  output logic [7:0] rd_data
);

  logic [7:0] mem [GB_TILE_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      for (int i = 0; i < GB_TILE_BYTES; i++) mem[i] <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
    end else if (wr_en) begin
      mem[byte_cnt] <= wr_data;
      byte_cnt      <= byte_cnt + 4'd1;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/vram_tile_injector.sv
// Buffers one translated 2bpp tile and stamps it into GB VRAM tile data in free bus slots.
// Optional: define VRAM_INJ_COLLISION_RESTART_EN to restart the tile when the CPU writes into it.
module vram_tile_injector
  import vram_inj_pkg::*;
#(
  parameter int          TILE_SIZE_BYTES = GB_TILE_BYTES,
  parameter logic [12:0] VRAM_TILE_START = 13'h0000,
  parameter logic [12:0] VRAM_TILE_END   = GB_TILE_DATA_END
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_enable,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_tile_index,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [7:0]  src_data,
  input  logic        src_last,
  input  logic        vram_access_ok,
  input  logic        cpu_vram_we,
  input  logic [12:0] cpu_vram_addr,
  output logic        inj_vram_we,
  output logic [12:0] inj_vram_addr,
  output logic [7:0]  inj_vram_wdata,
  output logic        inj_busy,
  output logic        inj_done,
  output logic        inj_error
);

  // Tile window size can never exceed the hardware tile count.
  localparam int TILE_SPAN =
    (int'(VRAM_TILE_END) - int'(VRAM_TILE_START) + 1) / TILE_SIZE_BYTES;
  localparam int TILE_LIMIT = (TILE_SPAN < GB_TILE_COUNT) ? TILE_SPAN : GB_TILE_COUNT;
  localparam logic [9:0] TILE_LIMIT_W = 10'(TILE_LIMIT);

  vram_inj_state_t state, next_state;
  logic [8:0]  tile;
  logic [3:0]  wr_idx;
  logic [3:0]  byte_cnt;
  logic [7:0]  rd_data;
  logic [12:0] tile_base;
  logic        grant, restart;
  logic        tile_load, cnt_clear, buf_we, wr_clear, wr_inc, error_set;

  tile_byte_buffer u_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (cnt_clear),
    .wr_en    (buf_we),
    .wr_data  (src_data),
    .rd_idx   (wr_idx),
    .byte_cnt (byte_cnt),
    .rd_data  (rd_data)
  );

  assign tile_base = VRAM_TILE_START + {tile, 4'b0000};
  assign grant     = vram_access_ok && !cpu_vram_we;

`ifdef VRAM_INJ_COLLISION_RESTART_EN
  logic [12:0] cpu_offset;
  assign cpu_offset = cpu_vram_addr - tile_base;
  assign restart    = cpu_vram_we && (cpu_offset[12:4] == 9'd0);
`else
  logic unused_cpu_addr;
  assign unused_cpu_addr = ^cpu_vram_addr;
  assign restart         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tile      <= '0;
      wr_idx    <= '0;
      inj_error <= 1'b0;
    end else begin
      state     <= next_state;
      inj_error <= error_set;
      if (tile_load) tile <= req_tile_index;
      if (wr_clear)    wr_idx <= '0;
      else if (wr_inc) wr_idx <= wr_idx + 4'd1;
    end
  end

  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    src_ready      = 1'b0;
    tile_load      = 1'b0;
    cnt_clear      = 1'b0;
    buf_we         = 1'b0;
    wr_clear       = 1'b0;
    wr_inc         = 1'b0;
    error_set      = 1'b0;
    inj_vram_we    = 1'b0;
    inj_vram_addr  = '0;
    inj_vram_wdata = '0;

    unique case (state)
      IDLE: begin
        req_ready = cfg_enable;
        if (cfg_enable && req_valid) begin
          tile_load = 1'b1;
          cnt_clear = 1'b1;
          if ({1'b0, req_tile_index} < TILE_LIMIT_W) next_state = LOAD;
          else                                       error_set  = 1'b1;
        end
      end
      LOAD: begin
        src_ready = 1'b1;
        if (src_valid) begin
          buf_we = 1'b1;
          if (byte_cnt == 4'd15) begin
            if (src_last) begin
              next_state = WRITE;
              wr_clear   = 1'b1;
            end else begin
              next_state = DRAIN;
              error_set  = 1'b1;
            end
          end else if (src_last) begin
            next_state = IDLE;
            error_set  = 1'b1;
          end
        end
      end
      DRAIN: begin
        src_ready = 1'b1;
        if (src_valid && src_last) next_state = IDLE;
      end
      WRITE: begin
        inj_vram_we = grant;
        if (grant) begin
          inj_vram_addr  = tile_base + {9'd0, wr_idx};
          inj_vram_wdata = rd_data;
        end
        // A collision rewind outranks completing the final byte.
        if (restart) begin
          wr_clear = 1'b1;
        end else if (grant) begin
          if (wr_idx == 4'd15) next_state = DONE;
          else                 wr_inc     = 1'b1;
        end
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (!cfg_enable && state != IDLE) begin
      next_state = IDLE;
      error_set  = 1'b0;
      buf_we     = 1'b0;
      wr_clear   = 1'b0;
      wr_inc     = 1'b0;
    end
  end

  assign inj_busy = (state != IDLE);
  assign inj_done = (state == DONE) && cfg_enable;

endmodule
